// File: rtl/cache_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_buffer_if
// Purpose  : Bundles the cache line buffer's request, fill, drain and status
//            signals. The DUT connects through the slave modport and the
//            requester/bus side through the master modport.
// Signals  : offset/rd_en/rd_data/rd_valid  - word read port
//            wr_en/wr_data                   - word write port
//            fill_start/mem_data/mem_valid/mem_ready   - line fill
//            drain_start/wb_data/wb_valid/wb_ready     - write-back drain
//            busy/dirty/done                 - status
// Revision : 1.0 - initial release
// ============================================================================
interface cache_line_buffer_if #(
  parameter int WORD_W = 8,
  parameter int WORDS  = 4
);
  localparam int OFFSET_W = $clog2(WORDS);

  logic [OFFSET_W-1:0] offset;
  logic                rd_en;
  logic [WORD_W-1:0]   rd_data;
  logic                rd_valid;
  logic                wr_en;
  logic [WORD_W-1:0]   wr_data;
  logic                fill_start;
  logic [WORD_W-1:0]   mem_data;
  logic                mem_valid;
  logic                mem_ready;
  logic                drain_start;
  logic [WORD_W-1:0]   wb_data;
  logic                wb_valid;
  logic                wb_ready;
  logic                busy;
  logic                dirty;
  logic                done;

  modport slave (
    input  offset, rd_en, wr_en, wr_data, fill_start, mem_data, mem_valid,
           drain_start, wb_ready,
    output rd_data, rd_valid, mem_ready, wb_data, wb_valid, busy, dirty, done
  );

  modport master (
    output offset, rd_en, wr_en, wr_data, fill_start, mem_data, mem_valid,
           drain_start, wb_ready,
    input  rd_data, rd_valid, mem_ready, wb_data, wb_valid, busy, dirty, done
  );
endinterface
`default_nettype wire

// File: rtl/cache_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_buffer
// Purpose  : One cache line of WORDS x WORD_W words. Supports single-word
//            read/write while idle, a line fill from memory (FILL) and a
//            write-back drain (DRAIN), with dirty tracking.
// Ports    : CLK   - clock, rising edge
//            RESET - synchronous active-high reset
//            bus   - cache_line_buffer_if.slave (read/write, fill, drain,
//                    status signals)
// Config   : LINE_BUF_CRIT_FWD_EN - when defined, reads are also serviced
//            during FILL (critical-word forwarding) and DRAIN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_buffer #(
  parameter int WORD_W = 8,
  parameter int WORDS  = 4
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  cache_line_buffer_if.slave  bus
);
  localparam int                  OFFSET_W = $clog2(WORDS);
  localparam logic [OFFSET_W-1:0] C_LAST   = OFFSET_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0]   line_q [WORDS];
  logic [WORD_W-1:0]   line_d [WORDS];
  logic                dirty_q, dirty_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
`ifdef LINE_BUF_CRIT_FWD_EN
  logic                pend_valid_q, pend_valid_d;
  logic [OFFSET_W-1:0] pend_off_q, pend_off_d;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    line_d     = line_q;
    dirty_d    = dirty_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef LINE_BUF_CRIT_FWD_EN
    pend_valid_d = pend_valid_q;
    pend_off_d   = pend_off_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          state_d = FILL;
          beat_d  = '0;
`ifdef LINE_BUF_CRIT_FWD_EN
          pend_valid_d = 1'b0;
`endif
        end else if (bus.drain_start) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          // Read samples line_q, so a same-offset write returns the old word.
          if (bus.rd_en) begin
            rd_data_d  = line_q[bus.offset];
            rd_valid_d = 1'b1;
          end
          if (bus.wr_en) begin
            line_d[bus.offset] = bus.wr_data;
            dirty_d            = 1'b1;
          end
        end
      end

      FILL: begin
`ifdef LINE_BUF_CRIT_FWD_EN
        // Serve an outstanding request as its word arrives.
        if (pend_valid_q && bus.mem_valid && (pend_off_q == beat_q)) begin
          rd_data_d    = bus.mem_data;
          rd_valid_d   = 1'b1;
          pend_valid_d = 1'b0;
        end
        // A new request replaces any pending one. Words below beat_q are
        // already in the line; the word at beat_q may be landing right now.
        if (bus.rd_en) begin
          if (bus.offset < beat_q) begin
            rd_data_d    = line_q[bus.offset];
            rd_valid_d   = 1'b1;
            pend_valid_d = 1'b0;
          end else if (bus.mem_valid && (bus.offset == beat_q)) begin
            rd_data_d    = bus.mem_data;
            rd_valid_d   = 1'b1;
            pend_valid_d = 1'b0;
          end else begin
            rd_valid_d   = 1'b0;
            pend_valid_d = 1'b1;
            pend_off_d   = bus.offset;
          end
        end
`endif
        if (bus.mem_valid) begin
          line_d[beat_q] = bus.mem_data;
          beat_d         = beat_q + 1'b1;
          if (beat_q == C_LAST) begin
            state_d = IDLE;
            dirty_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      DRAIN: begin
`ifdef LINE_BUF_CRIT_FWD_EN
        if (bus.rd_en) begin
          rd_data_d  = line_q[bus.offset];
          rd_valid_d = 1'b1;
        end
`endif
        if (bus.wb_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == C_LAST) begin
            state_d = IDLE;
            dirty_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      dirty_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < WORDS; i++) line_q[i] <= '0;
`ifdef LINE_BUF_CRIT_FWD_EN
      pend_valid_q <= 1'b0;
      pend_off_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      dirty_q    <= dirty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      for (int i = 0; i < WORDS; i++) line_q[i] <= line_d[i];
`ifdef LINE_BUF_CRIT_FWD_EN
      pend_valid_q <= pend_valid_d;
      pend_off_q   <= pend_off_d;
`endif
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.mem_ready = (state_q == FILL);
  assign bus.wb_valid  = (state_q == DRAIN);
  // Drain data comes straight from the line, so it holds while stalled.
  assign bus.wb_data   = line_q[beat_q];
  assign bus.busy      = (state_q != IDLE);
  assign bus.dirty     = dirty_q;
  assign bus.done      = done_q;
endmodule
`default_nettype wire

// File: doc/cache_line_buffer.md
CACHE_LINE_BUFFER -- requirements
Module: cache_line_buffer

Interface
REQ-001 Parameter WORD_W, default 8, bits per data word.
REQ-002 Parameter WORDS, default 4, words per line; power of two, >= 2; OFFSET_W = log2(WORDS).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 offset  input  OFFSET_W  word index for read or write.
REQ-006 rd_en  input  1  read request.
REQ-007 rd_data  output  WORD_W  registered read word.
REQ-008 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-009 wr_en  input  1  write request; wr_data goes into line[offset].
REQ-010 wr_data  input  WORD_W  write word.
REQ-011 fill_start  input  1  begin line fill from memory.
REQ-012 mem_data  input  WORD_W  fill beat data.
REQ-013 mem_valid  input  1  fill beat present.
REQ-014 mem_ready  output  1  high in FILL.
REQ-015 drain_start  input  1  begin write-back drain.
REQ-016 wb_data  output  WORD_W  drain beat data, line[beat].
REQ-017 wb_valid  output  1  high in DRAIN.
REQ-018 wb_ready  input  1  downstream accepts drain beat.
REQ-019 busy  output  1  state is not IDLE.
REQ-020 dirty  output  1  line modified since last fill or drain.
REQ-021 done  output  1  one-cycle pulse when a fill or drain completes.

Function
REQ-022 FSM states: IDLE, FILL, DRAIN; beat counter OFFSET_W bits wide.
REQ-023 IDLE priority: fill_start > drain_start > wr_en/rd_en.
REQ-024 IDLE, rd_en=1: rd_data=line[offset] and rd_valid=1 on the next cycle; latency 1 cycle.
REQ-025 IDLE, wr_en=1: line[offset]<=wr_data and dirty<=1 at the edge.
REQ-026 rd_en and wr_en in the same cycle at the same offset: rd_data returns the pre-write word.
REQ-027 fill_start in IDLE: go to FILL, beat<=0; any rd_en or wr_en in that cycle is dropped.
REQ-028 FILL: mem_ready=1; on each mem_valid=1 cycle, line[beat]<=mem_data and beat increments; no beat is consumed when mem_valid=0.
REQ-029 FILL, beat WORDS-1 stored: go to IDLE, beat wraps to 0, dirty<=0, done=1 on the next cycle.
REQ-030 drain_start in IDLE: go to DRAIN, beat<=0.
REQ-031 DRAIN: wb_valid=1, wb_data=line[beat] (combinational from the line), beat advances only when wb_ready=1; wb_data stays stable while wb_ready=0.
REQ-032 DRAIN, beat WORDS-1 accepted: go to IDLE, dirty<=0, done=1 on the next cycle.
REQ-033 When busy=1, wr_en, fill_start and drain_start are ignored; rd_en is handled per REQ-040.

Reset
REQ-034 RESET=1 at an edge: state<=IDLE, beat<=0, all line words<=0, dirty<=0.
REQ-035 Outputs after reset: rd_data=0, rd_valid=0, mem_ready=0, wb_valid=0, busy=0, done=0, wb_data=0.
REQ-036 RESET during FILL or DRAIN aborts the transfer at once; no done pulse.
REQ-037 RESET has priority over every other input.

Configuration
REQ-038 Macro LINE_BUF_CRIT_FWD_EN enables critical-word forwarding.
REQ-039 Without the macro, rd_en during FILL or DRAIN is dropped and rd_valid stays 0.
REQ-040 With the macro, rd_en during FILL latches a pending offset; one rd_valid pulse with line[pending] occurs the cycle after that word is stored, or the next cycle if it is already stored; a new rd_en replaces the pending offset; rd_en during DRAIN returns line[offset] with 1-cycle latency.

Verification
REQ-041 Reset, write 0xA1..0xA4 to offsets 0..3, read offset 2 -> rd_valid=1 with rd_data=0xA3 one cycle later, dirty=1.
REQ-042 Same-cycle write 0x55 and read at offset 1 (old value 0xA2) -> rd_data=0xA2; next read -> 0x55.
REQ-043 fill_start, then beats 0x10,0x20,0x30,0x40 with one mem_valid=0 gap -> line holds them, done pulses once, dirty=0, busy=0.
REQ-044 drain_start with wb_ready low 2 cycles at beat 1 -> wb_data held at 0x20; 4 beats accepted in order; then done=1.
REQ-045 RESET asserted after 2 fill beats -> busy=0, line all 0, no done pulse.
REQ-046 With LINE_BUF_CRIT_FWD_EN: rd_en offset 2 at the first fill beat -> rd_valid with rd_data=0x30 the cycle after beat 2, before done.
